// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port arbiter in front of a single-ported, fixed-latency
// data memory. Port 0 is the CPU data port, port 1 a secondary master.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle ack).
// Build option: define ARB_FIXED_PRI_EN for fixed priority (port 0 always
// wins contention); otherwise contention is resolved round-robin.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mio_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant,
  output logic          busy
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_d;
  logic          ack0_d, ack1_d;
  logic [DW-1:0] rdata_d;
  logic          mem_en_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          busy_d;
  logic          win;

  // CPU stall: low while the CPU request is outstanding and not yet acked
  assign mio_ready = ~(req0 & ~ack0);

  // Next-state, arbitration and next values of every registered output
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = 1'b0;
    win         = 1'b0;

`ifdef ARB_FIXED_PRI_EN
    win = ~req0;
`else
    win = (req0 & req1) ? ~grant : req1;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = ACCESS;
          grant_d     = win;
          mem_en_d    = 1'b1;
          mem_we_d    = win ? we1 : we0;
          mem_addr_d  = win ? addr1 : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          cnt_d       = CW'(MEM_LAT - 1);
          busy_d      = 1'b1;
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CW'(1);
          mem_en_d = 1'b1;
          mem_we_d = mem_we;
        end else begin
          if (!mem_we) begin
            rdata_d = mem_rdata;
          end
          ack0_d  = ~grant;
          ack1_d  = grant;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the memory strobe at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant     <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      rdata     <= rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates one single-ported data memory between two requesters: port 0 is the CPU data port (the MemRW/Addr_out/Data_out/Data_in side of the single-cycle core), and port 1 is a secondary master (debug loader / DMA). It sequences each access through a fixed-latency memory, returns read data with a one-cycle acknowledge, and produces the CPU's `MIO_ready` stall signal. It sits between the CPU top and the RAM/MIO bus.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 2, memory access cycles per transaction (legal range ≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-low (asserted when 0)
- `req0`  in  1  CPU request, held high until `ack0`
- `we0`  in  1  CPU write enable (1 = write)
- `addr0`  in  AW  CPU address
- `wdata0`  in  DW  CPU write data
- `ack0`  out  1  one-cycle completion pulse to CPU
- `req1` / `we1` / `addr1` / `wdata1` / `ack1`  same as port 0, for port 1
- `rdata`  out  DW  read data, valid while `ack0` or `ack1` is high
- `mio_ready`  out  1  `~(req0 & ~ack0)`, combinational
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid on the last access cycle
- `grant`  out  1  owner of the current or last transaction (0/1)
- `busy`  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when `req0|req1`.
  - Latch the winner's `we`, `addr` and `wdata` into registers, and set `grant`.
  - Load `cnt = MEM_LAT-1`.
- ACCESS:
  - `mem_en=1`; `mem_we/addr/wdata` come from the latched registers (stable for the whole access).
  - While `cnt≠0`, decrement `cnt`.
  - When `cnt==0`:
    - On a read, register `rdata <= mem_rdata`; on a write, `rdata` holds its previous value.
    - Set the granted port's ack; go to DONE.
- DONE: the granted ack is high for exactly this cycle; next state is IDLE. Requests are not sampled in DONE.
- Arbitration, round-robin:
  - If both ports request in IDLE, grant the port ≠ `grant`.
  - A single requester is always granted.
- Outside ACCESS, `mem_en=0` and `mem_we=0`; `mem_addr/wdata` hold their latched values.
- Request dropped during ACCESS: the transaction still completes and the ack is still pulsed.
- Request inputs changing during ACCESS have no effect on the memory outputs.

## Timing
- Reset values: state=IDLE, `ack0=ack1=0`, `rdata=0`, `mem_en=mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `grant=1` (so port 0 wins the first contention), `busy=0`, `cnt=0`.
- Latency: request seen in IDLE at cycle 0 → `mem_en` high in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
- Back-to-back: next grant is no earlier than cycle MEM_LAT+2, so peak throughput is one access per MEM_LAT+2 cycles.
- Requester rule: deassert, or present a new request, in the cycle after ack. A still-high request in the following IDLE cycle is treated as a new access.
- `mio_ready` drops in the same cycle `req0` rises (unless `ack0`) and returns high during the `ack0` cycle.
- Reset asserted mid-transaction: everything returns immediately to reset values, no ack is issued, and the memory strobe drops asynchronously.

## Configuration
- `ARB_FIXED_PRI_EN` defined: fixed priority. Port 0 (CPU) always wins contention; port 1 is granted only when `req0=0` in IDLE. `grant` still reports the owner.
- Not defined: round-robin as described in Operation.

## Test plan
- Single CPU read, MEM_LAT=2, `addr0=0x10`, `mem_rdata=0xDEADBEEF`:
  - `mem_en` high in cycles 1–2, `mem_we=0`, `mem_addr=0x10`.
  - `ack0` in cycle 3 with `rdata=0xDEADBEEF`.
  - `mio_ready=0` in cycles 0–2.
- Port 1 write, `addr1=0x20`, `wdata1=0x12345678`:
  - `mem_we=1` for 2 cycles with that address/data.
  - `ack1` in cycle 3; `rdata` unchanged.
- Both ports requesting continuously from reset:
  - Grants alternate 0,1,0,1, each ack 4 cycles apart.
  - With `ARB_FIXED_PRI_EN`, only port 0 is ever acked.
- `req0` dropped in cycle 1 of an access:
  - Access completes; `ack0` still pulses in cycle 3.
  - No new access starts in cycle 4.
- `rst=0` asserted in cycle 2 of an access:
  - `mem_en` drops immediately; no ack is issued.
  - After release, a fresh `req1` is granted and completes normally.
- MEM_LAT=1: `mem_en` high for one cycle, ack in cycle 2; back-to-back accesses every 3 cycles.
